trap_controller: RTL and testbench

Parametrised precise-trap sequencer for the 5-stage pipeline. It sits beside the hazard, forwarding and branch control logic. It arbitrates a vector of exception requests raised by the EXE stage and captures `sepc`/`scause`. It then runs a flush/drain/redirect sequence that stops the pipeline and restarts fetch at the trap vector. It also handles supervisor return (`sret`) by redirecting fetch to the saved `sepc`. Compared with the previous single-cause, combinational exception handler, this block adds a configurable number of sources, priority arbitration, registered trap state, drain timing and a redirect handshake.

---
 rtl/trap_pkg.sv | 22 ++
 rtl/prio_enc.sv | 20 ++
 rtl/trap_controller.sv | 115 +++++++++++
 tb/tb_trap_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and cause-code table for the precise-trap sequencer.
package trap_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_DRAIN,
    S_REDIRECT
  } trap_state_t;

  localparam int SCAUSE_W = 32;

  // Architectural codes for the first four sources: misaligned fetch, illegal, load/store misaligned.
  localparam logic [7:0] CAUSE_CODE [4] = '{8'd0, 8'd2, 8'd4, 8'd6};

  // Sources beyond the architectural four map onto reserved codes 24+i.
  function automatic logic [7:0] cause_code(input int unsigned idx);
    if (idx < 4) return CAUSE_CODE[idx[1:0]];
    return 8'(24 + idx);
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder with an any-set flag.
module prio_enc #(
  parameter int NUM_SRC = 4,
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    // Scan downward so the lowest set index is the last one written.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Precise-trap sequencer: arbitrates EXE exceptions and sret, then runs
// flush / drain / redirect so fetch restarts at the trap vector or sepc.
module trap_controller
  import trap_pkg::*;
#(
  parameter int               PC_W         = 15,
  parameter int               NUM_SRC      = 4,
  parameter int               CAUSE_W      = SCAUSE_W,
  parameter int               DRAIN_CYCLES = 2,
  parameter logic [PC_W-1:0]  TVEC         = 15'h0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] exc_req,
  input  logic [PC_W-1:0]    exc_pc,
  input  logic               trap_en,
  input  logic               sret_req,
  input  logic               redirect_ready,
  output logic [PC_W-1:0]    sepc,
  output logic [CAUSE_W-1:0] scause,
  output logic               flush_front,
  output logic               flush_exe,
  output logic               stall_front,
  output logic               redirect_valid,
  output logic [PC_W-1:0]    redirect_pc,
  output logic               busy,
  output logic [7:0]         drop_cnt
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  trap_state_t        state_q, state_d;
  logic [PC_W-1:0]    sepc_q, sepc_d;
  logic [CAUSE_W-1:0] scause_q, scause_d;
  logic [PC_W-1:0]    target_q, target_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         drop_q, drop_d;

  logic [IDX_W-1:0]   win_idx;
  logic               any_req;

  prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .req_i (exc_req),
    .idx_o (win_idx),
    .any_o (any_req)
  );

  always_comb begin
    state_d  = state_q;
    sepc_d   = sepc_q;
    scause_d = scause_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    unique case (state_q)
      S_IDLE: begin
        // An enabled exception outranks an sret raised in the same cycle.
        if (trap_en && any_req) begin
          sepc_d   = exc_pc;
          scause_d = CAUSE_W'(cause_code(32'(win_idx)));
          target_d = TVEC;
          state_d  = S_FLUSH;
        end else if (sret_req) begin
          target_d = sepc_q;
          state_d  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_REDIRECT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_REDIRECT: begin
        if (redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Requests arriving mid-sequence are dropped and tallied, saturating.
    if (state_q != S_IDLE && (any_req || sret_req) && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sepc_q   <= '0;
      scause_q <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      sepc_q   <= sepc_d;
      scause_q <= scause_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  assign sepc           = sepc_q;
  assign scause         = scause_q;
  assign redirect_pc    = target_q;
  assign drop_cnt       = drop_q;
  assign flush_front    = (state_q == S_FLUSH);
  assign flush_exe      = (state_q == S_FLUSH);
  assign stall_front    = (state_q != S_IDLE);
  assign redirect_valid = (state_q == S_REDIRECT);
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller with default parameters (DRAIN_CYCLES=2, TVEC=0x100).
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  exc_req = '0;
  logic [14:0] exc_pc = '0;
  logic        trap_en = 1'b1;
  logic        sret_req = 1'b0;
  logic        redirect_ready = 1'b0;
  logic [14:0] sepc;
  logic [31:0] scause;
  logic        flush_front, flush_exe, stall_front, redirect_valid, busy;
  logic [14:0] redirect_pc;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad = 0;

  trap_controller dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .exc_pc(exc_pc),
    .trap_en(trap_en), .sret_req(sret_req), .redirect_ready(redirect_ready),
    .sepc(sepc), .scause(scause), .flush_front(flush_front), .flush_exe(flush_exe),
    .stall_front(stall_front), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until redirect_valid rises (bounded); reports steps taken, or -1 on timeout.
  task automatic wait_redirect(output int n);
    n = -1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (redirect_valid === 1'b1) begin n = i; break; end
    end
    total++;
    if (n < 0) begin bad++; $display("FAIL wait_redirect: redirect_valid never rose in 16 cycles"); end
  endtask

  task automatic handshake(input string tag);
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    total++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
      bad++; $display("FAIL %s_handshake: busy=%b rv=%b required 0 0", tag, busy, redirect_valid);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if ({busy, flush_front, flush_exe, stall_front, redirect_valid} !== 5'b0) begin
      bad++; $display("FAIL %s_strobes: got %b required 00000", tag,
                      {busy, flush_front, flush_exe, stall_front, redirect_valid});
    end
    total++;
    if (sepc !== 15'h0 || scause !== 32'h0 || redirect_pc !== 15'h0 || drop_cnt !== 8'h0) begin
      bad++; $display("FAIL %s_regs: sepc=%h scause=%h rpc=%h drop=%0d required all 0", tag,
                      sepc, scause, redirect_pc, drop_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check_reset_outputs("reset");
  endtask

  task automatic test_trap();
    exc_req = 4'b0100; exc_pc = 15'h0040;
    step();                            // now cycle N+1
    exc_req = '0;
    total++;
    if ({flush_front, flush_exe, stall_front, busy} !== 4'b1111) begin
      bad++; $display("FAIL trap_flush: got %b required 1111", {flush_front, flush_exe, stall_front, busy});
    end
    total++;
    if (sepc !== 15'h0040 || scause !== 32'd4) begin
      bad++; $display("FAIL trap_capture: sepc=%h scause=%0d required 0040 4", sepc, scause);
    end
    step();                            // N+2, DRAIN
    total++;
    if ({flush_front, flush_exe, stall_front, redirect_valid} !== 4'b0010) begin
      bad++; $display("FAIL trap_drain: got %b required 0010",
                      {flush_front, flush_exe, stall_front, redirect_valid});
    end
    step();                            // N+3, DRAIN
    total++;
    if (redirect_valid !== 1'b0) begin bad++; $display("FAIL trap_early_rv: got %b required 0", redirect_valid); end
    step();                            // N+4, REDIRECT
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 15'h0100 || stall_front !== 1'b1) begin
      bad++; $display("FAIL trap_redirect: rv=%b rpc=%h stall=%b required 1 0100 1",
                      redirect_valid, redirect_pc, stall_front);
    end
    handshake("trap");
  endtask

  task automatic test_priority();
    int n;
    exc_req = 4'b1010; exc_pc = 15'h0022;
    step();
    exc_req = '0;
    total++;
    if (scause !== 32'd2 || sepc !== 15'h0022) begin
      bad++; $display("FAIL prio_cause: scause=%0d sepc=%h required 2 0022", scause, sepc);
    end
    wait_redirect(n);
    handshake("prio");
    trap_en = 1'b0; exc_req = 4'b1010; exc_pc = 15'h0077;
    step();
    total++;
    if (busy !== 1'b0 || scause !== 32'd2 || sepc !== 15'h0022) begin
      bad++; $display("FAIL prio_disabled: busy=%b scause=%0d sepc=%h required 0 2 0022", busy, scause, sepc);
    end
    exc_req = '0; trap_en = 1'b1;
  endtask

  task automatic test_return();
    int n;
    exc_req = 4'b0100; exc_pc = 15'h0040;
    step();
    exc_req = '0;
    wait_redirect(n);
    handshake("ret_setup");
    sret_req = 1'b1;
    step();
    sret_req = 1'b0;
    total++;
    if (busy !== 1'b1 || sepc !== 15'h0040 || scause !== 32'd4) begin
      bad++; $display("FAIL ret_state: busy=%b sepc=%h scause=%0d required 1 0040 4", busy, sepc, scause);
    end
    wait_redirect(n);
    total++;
    if (redirect_pc !== 15'h0040) begin bad++; $display("FAIL ret_target: rpc=%h required 0040", redirect_pc); end
    handshake("ret");
    sret_req = 1'b1; exc_req = 4'b0001; exc_pc = 15'h0050;
    step();
    sret_req = 1'b0; exc_req = '0;
    total++;
    if (scause !== 32'd0 || sepc !== 15'h0050) begin
      bad++; $display("FAIL ret_vs_exc_capture: scause=%0d sepc=%h required 0 0050", scause, sepc);
    end
    wait_redirect(n);
    total++;
    if (redirect_pc !== 15'h0100) begin bad++; $display("FAIL ret_vs_exc_target: rpc=%h required 0100", redirect_pc); end
    handshake("ret_vs_exc");
    total++;
    if (drop_cnt !== 8'd0) begin bad++; $display("FAIL ret_drop: drop=%0d required 0", drop_cnt); end
  endtask

  task automatic test_backpressure();
    int n;
    exc_req = 4'b0100; exc_pc = 15'h0060;
    step();
    exc_req = '0;
    wait_redirect(n);
    exc_req = 4'b0001; sret_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 15'h0100) begin
        bad++; $display("FAIL bp_hold%0d: rv=%b rpc=%h required 1 0100", i, redirect_valid, redirect_pc);
      end
    end
    exc_req = '0; sret_req = 1'b0;
    total++;
    if (drop_cnt !== 8'd5) begin bad++; $display("FAIL bp_drop: drop=%0d required 5", drop_cnt); end
    handshake("bp");
    total++;
    if (drop_cnt !== 8'd5) begin bad++; $display("FAIL bp_drop_after: drop=%0d required 5", drop_cnt); end
  endtask

  task automatic test_saturation();
    exc_req = 4'b0001; exc_pc = 15'h0010;
    step();                            // trap accepted; held requests now count
    exc_req = 4'b0010;
    for (int i = 0; i < 300; i++) step();
    exc_req = '0;
    total++;
    if (drop_cnt !== 8'd255 || redirect_valid !== 1'b1) begin
      bad++; $display("FAIL sat_drop: drop=%0d rv=%b required 255 1", drop_cnt, redirect_valid);
    end
    handshake("sat");
  endtask

  task automatic test_reset_drain();
    int n;
    exc_req = 4'b0010; exc_pc = 15'h0033;
    step();                            // FLUSH
    exc_req = '0;
    step();                            // DRAIN
    total++;
    if (stall_front !== 1'b1 || flush_front !== 1'b0) begin
      bad++; $display("FAIL rd_in_drain: stall=%b flush=%b required 1 0", stall_front, flush_front);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_outputs("rd");
    exc_req = 4'b0001; exc_pc = 15'h0030;
    step();
    exc_req = '0;
    total++;
    if (scause !== 32'd0 || sepc !== 15'h0030 || flush_exe !== 1'b1) begin
      bad++; $display("FAIL rd_fresh_capture: scause=%0d sepc=%h fe=%b required 0 0030 1", scause, sepc, flush_exe);
    end
    wait_redirect(n);
    total++;
    if (n !== 3 || redirect_pc !== 15'h0100) begin
      bad++; $display("FAIL rd_fresh_latency: steps=%0d rpc=%h required 3 0100", n, redirect_pc);
    end
    handshake("rd");
  endtask

  initial begin
    test_reset();
    test_trap();
    test_priority();
    test_return();
    test_backpressure();
    test_saturation();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
